// File: rtl/multi_byte_alu_sequencer_if.sv
// Bundle for the wide ALU sequencer: request, response and ALU drive/return.
// slave = sequencer side, master = control logic plus ALU side.
interface multi_byte_alu_sequencer_if #(
  parameter int BYTES         = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int CONTROL_WIDTH = 3
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [BYTES*8-1:0]       req_a_i;
  logic [BYTES*8-1:0]       req_b_i;
  logic [CONTROL_WIDTH-1:0] req_f_i;
  logic                     req_cb_i;

  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [BYTES*8-1:0]       rsp_y_o;
  logic                     rsp_cb_o;
  logic [1:0]               rsp_flag_o;

  logic [DATA_WIDTH-1:0]    alu_a_o;
  logic [DATA_WIDTH-1:0]    alu_b_o;
  logic [CONTROL_WIDTH-1:0] alu_f_o;
  logic                     alu_cb_o;
  logic [DATA_WIDTH-1:0]    alu_y_i;
  logic                     alu_cb_i;
  logic [1:0]               alu_flag_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i,
    input  req_f_i, req_cb_i, rsp_ready_i,
    input  alu_y_i, alu_cb_i, alu_flag_i,
    output req_ready_o, rsp_valid_o,
    output rsp_y_o, rsp_cb_o, rsp_flag_o,
    output alu_a_o, alu_b_o, alu_f_o, alu_cb_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i,
    output req_f_i, req_cb_i, rsp_ready_i,
    output alu_y_i, alu_cb_i, alu_flag_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_y_o, rsp_cb_o, rsp_flag_o,
    input  alu_a_o, alu_b_o, alu_f_o, alu_cb_o
  );
endinterface

// File: rtl/multi_byte_alu_sequencer.sv
// Wide ALU sequencer: runs BYTES x 8-bit ops on one eight_bit_alu, LSB first.
// Ports: clk_i, rst_ni (async low), bus (req/rsp handshakes + ALU drive/return).
package multi_byte_alu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int CONTROL_WIDTH = 3;

  localparam logic [2:0] OUTPUT_A         = 3'd0;
  localparam logic [2:0] OUTPUT_B         = 3'd1;
  localparam logic [2:0] OUTPUT_A_PLUS_B  = 3'd2;
  localparam logic [2:0] OUTPUT_A_MINUS_B = 3'd3;
  localparam logic [2:0] OUTPUT_A_AND_B   = 3'd4;
  localparam logic [2:0] OUTPUT_A_OR_B    = 3'd5;
  localparam logic [2:0] OUTPUT_A_XOR_B   = 3'd6;
  localparam logic [2:0] OUTPUT_NOT_A     = 3'd7;

  localparam logic [1:0] DEFAULT_FLAG  = 2'b00;
  localparam logic [1:0] ZERO_FLAG     = 2'b01;
  localparam logic [1:0] NEGATIVE_FLAG = 2'b10;
  localparam logic [1:0] OVERFLOW_FLAG = 2'b11;
endpackage

module multi_byte_alu_sequencer
  import multi_byte_alu_pkg::*;
#(
  parameter int BYTES = 4
) (
  input logic clk_i,
  input logic rst_ni,
  multi_byte_alu_sequencer_if.slave bus
);

  localparam int W  = BYTES * 8;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]               state_q;
  logic [W-1:0]             a_q;
  logic [W-1:0]             b_q;
  logic [W-1:0]             y_q;
  logic [CONTROL_WIDTH-1:0] f_q;
  logic                     cb_in_q;
  logic                     carry_q;
  logic [1:0]               flag_q;
  logic [IW-1:0]            idx_q;

  logic                     run;
  logic                     last;
  logic [IW+2:0]            sh;
  logic [7:0]               a_byte;
  logic [7:0]               b_byte;
  logic [W-1:0]             mask;
  logic [W-1:0]             y_next;
  logic [1:0]               flag_d;
  logic                     unused_alu_flag;

  assign run  = (state_q == RUN);
  assign last = (idx_q == IW'(BYTES - 1));
  assign sh   = {idx_q, 3'b000};

  assign a_byte = 8'(a_q >> sh);
  assign b_byte = 8'(b_q >> sh);

  // Splice the incoming ALU byte into the partial result at idx.
  assign mask   = W'(8'hFF) << sh;
  assign y_next = (y_q & ~mask)
                | (W'(bus.alu_y_i) << sh);

  // Word flag is judged on the completed word and the top-byte carry.
  always_comb begin
    flag_d = DEFAULT_FLAG;
    if (f_q == OUTPUT_A_PLUS_B && bus.alu_cb_i)
      flag_d = OVERFLOW_FLAG;
    else if (f_q == OUTPUT_A_MINUS_B && bus.alu_cb_i)
      flag_d = NEGATIVE_FLAG;
    else if (y_next == '0)
      flag_d = ZERO_FLAG;
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == DONE);
  assign bus.rsp_y_o     = y_q;
  assign bus.rsp_cb_o    = carry_q;
  assign bus.rsp_flag_o  = flag_q;

  assign bus.alu_a_o  = run ? a_byte : '0;
  assign bus.alu_b_o  = run ? b_byte : '0;
  assign bus.alu_f_o  = run ? f_q : '0;
  assign bus.alu_cb_o = run &
    ((idx_q == '0) ? cb_in_q : carry_q);

  assign unused_alu_flag = ^bus.alu_flag_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      cb_in_q <= 1'b0;
      carry_q <= 1'b0;
      flag_q  <= DEFAULT_FLAG;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            a_q     <= bus.req_a_i;
            b_q     <= bus.req_b_i;
            f_q     <= bus.req_f_i;
            cb_in_q <= bus.req_cb_i;
            idx_q   <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            flag_q  <= DEFAULT_FLAG;
            state_q <= RUN;
          end
        end
        RUN: begin
          y_q     <= y_next;
          carry_q <= bus.alu_cb_i;
          if (last) begin
            flag_q  <= flag_d;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
